sample_ctrl: RTL and testbench

//  Upstream sequencer for the 10-bit sample counter: detects each new sample from the host on

---
 rtl/sample_ctrl.sv | 123 ++++++++++++
 tb/tb_sample_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_ctrl.sv
// Host-side sequencer for the sample counter: edge-detects data_ready, latches the sample,
// then pulses load_en and count_up and checks the counter flag once it has settled.
module sample_ctrl #(
  parameter int NUM_SAMPLES = 1000,
  parameter int CNT_W       = 10,
  parameter int DATA_W      = 16,
  parameter int SETTLE      = 2
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              data_ready,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              one_k_samples,
  output logic              count_up,
  output logic              load_en,
  output logic [DATA_W-1:0] sample_out,
  output logic              modwait,
  output logic [CNT_W-1:0]  sample_idx,
  output logic              done,
  output logic              err
);

  localparam int SW = (SETTLE > 2) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [CNT_W-1:0] IDX_MAX     = CNT_W'(NUM_SAMPLES);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COUNT, S_SETTLE, S_WAIT_LOW, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic              dr_prev;
  logic              armed;
  logic [SW-1:0]     settle_cnt;
  logic              new_smp;
  logic              at_limit;
  logic              err_set;

  logic              count_up_nxt, load_en_nxt, modwait_nxt, done_nxt, err_nxt;
  logic [DATA_W-1:0] sample_out_nxt;
  logic [CNT_W-1:0]  sample_idx_nxt;

  // A level held high across reset release must not count as a new sample:
  // data_ready has to be seen low once before the first edge is accepted.
  assign new_smp  = data_ready & ~dr_prev & armed;
  assign at_limit = (sample_idx == IDX_MAX);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state      <= S_IDLE;
      dr_prev    <= 1'b0;
      armed      <= 1'b0;
      settle_cnt <= '0;
      count_up   <= 1'b0;
      load_en    <= 1'b0;
      modwait    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      sample_out <= '0;
      sample_idx <= '0;
    end else begin
      state      <= state_nxt;
      dr_prev    <= data_ready;
      if (!data_ready) armed <= 1'b1;
      settle_cnt <= (state == S_SETTLE) ? settle_cnt + SW'(1) : '0;
      count_up   <= count_up_nxt;
      load_en    <= load_en_nxt;
      modwait    <= modwait_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      sample_out <= sample_out_nxt;
      sample_idx <= sample_idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    case (state)
      S_IDLE:  if (new_smp) state_nxt = S_LOAD;
      S_LOAD: begin
        err_set   = new_smp;
        state_nxt = S_COUNT;
      end
      S_COUNT: begin
        err_set   = new_smp;
        state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        err_set = new_smp;
        // Flag and local index are compared only once the counter has caught up.
        if (settle_cnt == SETTLE_LAST) begin
          if (at_limit && one_k_samples) begin
            state_nxt = S_DONE;
          end else begin
            if (at_limit != one_k_samples) err_set = 1'b1;
            state_nxt = S_WAIT_LOW;
          end
        end
      end
      S_WAIT_LOW: begin
        err_set = new_smp;
        if (!data_ready) state_nxt = S_IDLE;
      end
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    count_up_nxt   = (state_nxt == S_COUNT);
    load_en_nxt    = (state_nxt == S_LOAD);
    done_nxt       = (state_nxt == S_DONE);
    modwait_nxt    = (state_nxt == S_LOAD) || (state_nxt == S_COUNT) ||
                     (state_nxt == S_SETTLE) || (state_nxt == S_WAIT_LOW);
    err_nxt        = err | err_set;
    sample_out_nxt = sample_out;
    sample_idx_nxt = sample_idx;
    if (state == S_IDLE && new_smp) sample_out_nxt = sample_data;
    if (state == S_LOAD && !at_limit) sample_idx_nxt = sample_idx + CNT_W'(1);
  end

endmodule

// File: tb/tb_sample_ctrl.sv
// Bench for sample_ctrl: scenario tasks with randomized samples, checked against a
// per-handshake model of accepted count, done and err; includes a model of the real counter.
module tb_sample_ctrl;
  localparam int NUM    = 1000;
  localparam int CNT_W  = 10;
  localparam int DATA_W = 16;
  localparam int SETTLE = 2;

  logic              clk = 1'b0;
  logic              n_reset = 1'b0;
  logic              data_ready = 1'b0;
  logic [DATA_W-1:0] sample_data = '0;
  logic              one_k_samples;
  logic              count_up, load_en, modwait, done, err;
  logic [DATA_W-1:0] sample_out;
  logic [CNT_W-1:0]  sample_idx;

  int checks = 0;
  int errors = 0;

  // 0: real counter, 1: flag forced high, 2: flag forced low
  int   one_k_mode = 0;
  int   ctr_cnt;
  logic ctr_flag;

  sample_ctrl #(.NUM_SAMPLES(NUM), .CNT_W(CNT_W), .DATA_W(DATA_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .n_reset(n_reset), .data_ready(data_ready), .sample_data(sample_data),
    .one_k_samples(one_k_samples), .count_up(count_up), .load_en(load_en),
    .sample_out(sample_out), .modwait(modwait), .sample_idx(sample_idx),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Counter with registered flag: valid two cycles after the count_up strobe.
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ctr_cnt  <= 0;
      ctr_flag <= 1'b0;
    end else begin
      if (count_up) ctr_cnt <= ctr_cnt + 1;
      ctr_flag <= (ctr_cnt >= NUM);
    end
  end

  assign one_k_samples = (one_k_mode == 1) ? 1'b1 : (one_k_mode == 2) ? 1'b0 : ctr_flag;

  task automatic apply_reset();
    @(negedge clk);
    n_reset    = 1'b0;
    data_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
  endtask

  // Stimulus only: raise data_ready for 'hold' cycles, then wait for modwait to fall.
  task automatic run_handshake(input logic [DATA_W-1:0] d, input int hold,
                               output int n_cu, output int n_le, output int n_both,
                               output bit tmo);
    n_cu = 0; n_le = 0; n_both = 0; tmo = 1'b1;
    @(negedge clk);
    sample_data = d;
    data_ready  = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (count_up) n_cu++;
      if (load_en) n_le++;
      if (count_up && load_en) n_both++;
      if (i > hold && !modwait) begin
        tmo = 1'b0;
        break;
      end
      if (i == hold) data_ready = 1'b0;
    end
    data_ready = 1'b0;
  endtask

  task automatic test_reset();
    int strobes = 0;
    int n_cu, n_le, n_both;
    bit tmo;
    n_reset    = 1'b0;
    data_ready = 1'b1;
    sample_data = 16'h1357;
    repeat (3) @(negedge clk);
    checks++;
    if ({count_up, load_en, modwait, done, err, sample_out, sample_idx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got cu=%0b le=%0b mw=%0b dn=%0b er=%0b so=%h idx=%0d, expected all 0",
               count_up, load_en, modwait, done, err, sample_out, sample_idx);
    end
    n_reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (count_up || load_en || modwait) strobes++;
    end
    checks++;
    if (strobes !== 0) begin
      errors++;
      $display("FAIL reset_held_high: got %0d busy/strobe cycles, expected 0", strobes);
    end
    data_ready = 1'b0;
    @(negedge clk);
    run_handshake(16'h2468, 2, n_cu, n_le, n_both, tmo);
    checks++;
    if (n_cu !== 1 || tmo !== 1'b0 || sample_idx !== 10'd1) begin
      errors++;
      $display("FAIL reset_first_rise: got cu=%0d tmo=%0b idx=%0d, expected cu=1 tmo=0 idx=1",
               n_cu, tmo, sample_idx);
    end
  endtask

  task automatic test_single();
    logic [2:0] obs;
    apply_reset();
    @(negedge clk);
    sample_data = 16'hA5A5;
    data_ready  = 1'b1;
    @(negedge clk);
    checks++;
    if ({load_en, count_up, modwait} !== 3'b101 || sample_out !== 16'hA5A5) begin
      errors++;
      $display("FAIL single_load: got le/cu/mw=%b so=%h, expected 101 so=a5a5",
               {load_en, count_up, modwait}, sample_out);
    end
    @(negedge clk);
    checks++;
    if ({load_en, count_up, modwait} !== 3'b011 || sample_idx !== 10'd1) begin
      errors++;
      $display("FAIL single_count: got le/cu/mw=%b idx=%0d, expected 011 idx=1",
               {load_en, count_up, modwait}, sample_idx);
    end
    for (int i = 0; i < SETTLE + 2; i++) begin
      @(negedge clk);
      obs = {load_en, count_up, modwait};
      checks++;
      if (obs !== 3'b001) begin
        errors++;
        $display("FAIL single_settle_wait[%0d]: got le/cu/mw=%b, expected 001", i, obs);
      end
    end
    data_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (modwait !== 1'b0 || err !== 1'b0 || done !== 1'b0 || sample_idx !== 10'd1) begin
      errors++;
      $display("FAIL single_release: got mw=%0b err=%0b done=%0b idx=%0d, expected 0 0 0 1",
               modwait, err, done, sample_idx);
    end
  endtask

  task automatic test_overrun();
    int extra = 0;
    int n_cu, n_le, n_both;
    bit tmo;
    bit released = 1'b0;
    apply_reset();
    @(negedge clk);
    sample_data = 16'h1234;
    data_ready  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    data_ready = 1'b0;
    @(negedge clk);
    sample_data = 16'hBEEF;
    data_ready  = 1'b1;
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || sample_idx !== 10'd1 || sample_out !== 16'h1234) begin
      errors++;
      $display("FAIL overrun_flag: got err=%0b idx=%0d so=%h, expected err=1 idx=1 so=1234",
               err, sample_idx, sample_out);
    end
    data_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (count_up || load_en) extra++;
      if (!modwait) begin
        released = 1'b1;
        break;
      end
    end
    checks++;
    if (extra !== 0 || !released || err !== 1'b1 || sample_idx !== 10'd1) begin
      errors++;
      $display("FAIL overrun_drop: got strobes=%0d released=%0b err=%0b idx=%0d, expected 0 1 1 1",
               extra, released, err, sample_idx);
    end
    run_handshake(16'h4321, 3, n_cu, n_le, n_both, tmo);
    checks++;
    if (n_cu !== 1 || sample_idx !== 10'd2 || sample_out !== 16'h4321 || err !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got cu=%0d idx=%0d so=%h err=%0b, expected 1 2 4321 1",
               n_cu, sample_idx, sample_out, err);
    end
  endtask

  task automatic test_midop_reset();
    int strobes = 0;
    int n_cu, n_le, n_both;
    bit tmo;
    apply_reset();
    @(negedge clk);
    sample_data = 16'h0F0F;
    data_ready  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (count_up !== 1'b1) begin
      errors++;
      $display("FAIL midop_count_cycle: got cu=%0b, expected 1", count_up);
    end
    n_reset = 1'b0;
    #1;
    checks++;
    if ({count_up, load_en, modwait, done, err} !== 5'b0 || sample_idx !== '0) begin
      errors++;
      $display("FAIL midop_reset: got cu/le/mw/dn/er=%b idx=%0d, expected 00000 idx=0",
               {count_up, load_en, modwait, done, err}, sample_idx);
    end
    @(negedge clk);
    n_reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (count_up || load_en || modwait) strobes++;
    end
    data_ready = 1'b0;
    @(negedge clk);
    run_handshake(16'h7777, 1, n_cu, n_le, n_both, tmo);
    checks++;
    if (strobes !== 0 || n_cu !== 1 || sample_idx !== 10'd1 || tmo !== 1'b0) begin
      errors++;
      $display("FAIL midop_recover: got held_strobes=%0d cu=%0d idx=%0d tmo=%0b, expected 0 1 1 0",
               strobes, n_cu, sample_idx, tmo);
    end
  endtask

  // mode_at(s): flag source for sample s; force_at < 0 means real counter throughout.
  task automatic run_sequence(input string tag, input int n, input int force_at,
                              output int acc, output bit m_err, output bit m_done);
    int n_cu, n_le, n_both, exp_cu, exp_idx;
    bit tmo, flag;
    logic [DATA_W-1:0] d, last_d;
    acc = 0; m_err = 1'b0; m_done = 1'b0; last_d = '0;
    for (int s = 1; s <= n; s++) begin
      if (force_at >= 0) one_k_mode = (s == force_at) ? 1 : 2;
      d = DATA_W'($urandom);
      run_handshake(d, int'($urandom_range(1, 4)), n_cu, n_le, n_both, tmo);
      exp_cu = m_done ? 0 : 1;
      if (!m_done) begin
        acc++;
        last_d = d;
        flag = (force_at >= 0) ? (s == force_at) : (acc >= NUM);
        if (acc >= NUM && flag) m_done = 1'b1;
        else if ((acc >= NUM) != flag) m_err = 1'b1;
      end
      exp_idx = (acc > NUM) ? NUM : acc;
      checks++;
      if (n_cu !== exp_cu || n_le !== exp_cu || n_both !== 0 || tmo !== 1'b0) begin
        errors++;
        $display("FAIL %s_strobes[%0d]: got cu=%0d le=%0d both=%0d tmo=%0b, expected cu=le=%0d both=0 tmo=0",
                 tag, s, n_cu, n_le, n_both, tmo, exp_cu);
      end
      checks++;
      if (sample_idx !== CNT_W'(exp_idx) || sample_out !== last_d) begin
        errors++;
        $display("FAIL %s_data[%0d]: got idx=%0d so=%h, expected idx=%0d so=%h",
                 tag, s, sample_idx, sample_out, exp_idx, last_d);
      end
      checks++;
      if (err !== m_err || done !== m_done) begin
        errors++;
        $display("FAIL %s_flags[%0d]: got err=%0b done=%0b, expected err=%0b done=%0b",
                 tag, s, err, done, m_err, m_done);
      end
    end
  endtask

  task automatic test_full_run();
    int acc;
    bit m_err, m_done;
    one_k_mode = 0;
    apply_reset();
    run_sequence("full", NUM + 1, -1, acc, m_err, m_done);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || sample_idx !== 10'd1000 || modwait !== 1'b0) begin
      errors++;
      $display("FAIL full_end: got done=%0b err=%0b idx=%0d mw=%0b, expected 1 0 1000 0",
               done, err, sample_idx, modwait);
    end
  endtask

  task automatic test_mismatch();
    int acc;
    bit m_err, m_done;
    apply_reset();
    run_sequence("mismatch", NUM, 5, acc, m_err, m_done);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || sample_idx !== 10'd1000) begin
      errors++;
      $display("FAIL mismatch_end: got err=%0b done=%0b idx=%0d, expected 1 0 1000",
               err, done, sample_idx);
    end
    one_k_mode = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_midop_reset();
    test_full_run();
    test_mismatch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
